acia_rx_fifo: RTL and testbench
===============================

# acia_rx_fifo

Buffered asynchronous serial receiver for the 6502 ACIA peripheral path. It samples the raw `rx` pin, deframes 8N1 characters and queues them in a small FIFO. The ACIA register logic drains the queue one byte per data-register read, so a burst of characters survives a slow interrupt handler. It sits directly upstream of the ACIA status/data register logic and replaces the unbuffered receive path.

## Interface
- `clk_freq`, 4000000, system clock frequency in Hz.
- `sym_rate`, 9600, bit rate; `sym_cnt = clk_freq / sym_rate` (416 at defaults), counter width `$clog2(sym_cnt)`.
- `FIFO_DEPTH`, 8, number of FIFO entries; must be a power of 2 and at least 2.
- `clk` in 1: system clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `pclk` in 1: peripheral clock enable; all state, including the synchronizer, advances only on `clk` edges where `pclk=1`.
- `rx_serial` in 1: raw serial input, idle high, asynchronous to `clk`.
- `rd_stb` in 1: pop request for the head entry, sampled on enabled cycles.
- `clr_err` in 1: clears `rx_err` and `rx_ovr`, sampled on enabled cycles.
- `rx_dat` out 8: head-of-FIFO byte; only meaningful while `rx_rdy=1`.
- `rx_rdy` out 1: FIFO non-empty.
- `rx_err` out 1: sticky framing error.
- `rx_ovr` out 1: sticky overrun flag.
- `rx_level` out `$clog2(FIFO_DEPTH)+1`: current number of FIFO entries.

## Operation
- **Synchronizer:** two flops on `rx_serial`, both reset to 1. `rxs` is the second stage.
- **Receive FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. The bit counter and bit index clear on every state change.
- IDLE: `rxs=0` → START.
- START: at `cnt == sym_cnt/2-1`, sample `rxs`. If 1, treat as a glitch → IDLE. If 0 → DATA.
- DATA: at `cnt == sym_cnt-1`, shift `rxs` into the shift register, LSB first. After the 8th bit → STOP.
- STOP: at `cnt == sym_cnt-1`, sample `rxs`.
  - 1: push the byte → IDLE.
  - 0: discard the byte, set `rx_err`, → WAIT_HIGH.
- WAIT_HIGH (break/framing recovery): stay until `rxs=1` → IDLE.
- **FIFO:** circular buffer with read/write pointers one bit wider than the index; `rx_level` is the difference of the two pointers.
  - Push while full: the new byte is dropped and `rx_ovr` is set. Stored data is unchanged.
  - Push and `rd_stb` on the same cycle while full: both take effect, the level stays at FIFO_DEPTH, no overrun.
  - Push and pop on the same cycle while empty: the push happens and the pop is ignored, so the level becomes 1.
  - `rd_stb` while empty: ignored.
- **Error flags:** `clr_err` has priority below a new set event on the same cycle, so a flag set in that cycle stays set.
- **Reset values:** `rx_dat=0x00`, `rx_rdy=0`, `rx_err=0`, `rx_ovr=0`, `rx_level=0`, FSM=IDLE, pointers=0.
- **Reset mid-character:** the partial character is lost and no push occurs.

## Timing
- All latencies below are counted in enabled cycles (cycles with `pclk=1`).
- Start-edge latency: `rxs` falls 2 cycles after `rx_serial`; START is entered 1 cycle later.
- Stop-bit sample and push occur `sym_cnt/2 + 9*sym_cnt` cycles after START is entered.
- `rx_rdy`, `rx_dat` and `rx_level` are registered; they update on the cycle after the push.
- A pop takes effect on the `rd_stb` cycle; the next head byte appears on `rx_dat` on the following cycle.
- Sample point: bit centre, with tolerance ±sym_cnt/2 per frame. Back-to-back characters (stop bit immediately followed by a start bit) are received without loss.

## Configuration
- `ACIA_RX_FIFO_EN` defined: the FIFO has FIFO_DEPTH entries as described above.
- `ACIA_RX_FIFO_EN` undefined: a single holding register replaces the FIFO.
  - `rx_level` is 0 or 1.
  - A push while the register is full sets `rx_ovr` and drops the new byte.
  - Port list unchanged.

## Structure
- Shared package `acia_pkg` holds:
  - the FSM state enum (`RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`, `RX_WAIT_HIGH`);
  - the `sym_cnt` / counter-width constant function;
  - the 8-bit data-width constant.
- One sub-module: `acia_sync_fifo` (parameterised by depth and width; push, pop, full, empty, level). The deframer FSM stays in the top module.

## Test plan
- **Single character:** `pclk=1`, send 0xA5 8N1 at sym_cnt=416 → `rx_rdy` rises `2+1+208+3744+1` cycles (±1) after the start edge; `rx_dat=0xA5`, `rx_level=1`.
- **Glitch rejection:** `rx_serial` low for 100 cycles then high → FSM returns to IDLE, no push, `rx_err=0`.
- **Framing error:** send 0x3C with stop bit 0, then line high → `rx_err=1`, `rx_level` unchanged. `clr_err` pulse → `rx_err=0`.
- **Overflow:** send 9 bytes 0x01..0x09 with no reads → `rx_level=8`, `rx_ovr=1`; 8 pops return 0x01..0x08 in order.
- **Simultaneous push/pop:** with the FIFO full, assert `rd_stb` on the push cycle → level stays 8, `rx_ovr=0`, the last byte is retained.
- **Async reset mid-frame:** assert `reset_n=0` at the 4th data bit → all outputs return to reset values immediately; a following byte 0x5A is received correctly.

Source files
------------

// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA receive path: data width, deframer states,
// and the bit-period constant functions.
package acia_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    function automatic int sym_cnt_calc(input int clk_freq, input int sym_rate);
        return clk_freq / sym_rate;
    endfunction

    function automatic int cnt_w_calc(input int clk_freq, input int sym_rate);
        return $clog2(clk_freq / sym_rate);
    endfunction

endpackage

// File: rtl/acia_sync_fifo.sv
// Single-clock circular FIFO with extra-bit pointers; level = wr_ptr - rd_ptr.
// A pop on a full FIFO frees the slot that a same-cycle push then fills.
module acia_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = en && pop && !empty;
    assign do_push = en && push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/acia_rx_fifo.sv
// Buffered 8N1 receiver: synchronizer, deframer FSM, receive queue and sticky flags.
// ACIA_RX_FIFO_EN selects the FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module acia_rx_fifo
    import acia_pkg::*;
#(
    parameter int clk_freq   = 4000000,
    parameter int sym_rate   = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          pclk,
    input  logic                          rx_serial,
    input  logic                          rd_stb,
    input  logic                          clr_err,
    output logic [DATA_W-1:0]             rx_dat,
    output logic                          rx_rdy,
    output logic                          rx_err,
    output logic                          rx_ovr,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

    localparam int SYM_CNT = sym_cnt_calc(clk_freq, sym_rate);
    localparam int CNT_W   = cnt_w_calc(clk_freq, sym_rate);
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W   = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(SYM_CNT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(SYM_CNT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic              rx_meta;
    logic              rxs;
    rx_state_t         rx_state;
    rx_state_t         state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              shift_en;
    logic              push;
    logic              frame_err;
    logic              full;
    logic              empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else if (pclk) begin
            rx_meta <= rx_serial;
            rxs     <= rx_meta;
        end
    end

    always_comb begin
        state_nx  = rx_state;
        shift_en  = 1'b0;
        push      = 1'b0;
        frame_err = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rxs) state_nx = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_M1) state_nx = rxs ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (cnt == FULL_M1) begin
                    shift_en = 1'b1;
                    if (bit_idx == LAST_BIT) state_nx = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL_M1) begin
                    if (rxs) begin
                        push     = 1'b1;
                        state_nx = RX_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_nx  = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rxs) state_nx = RX_IDLE;
            end
            default: state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else if (pclk) begin
            rx_state <= state_nx;
            if (state_nx != rx_state) begin
                cnt     <= '0;
                bit_idx <= '0;
            end else if (shift_en) begin
                cnt     <= '0;
                bit_idx <= bit_idx + BIT_W'(1);
            end else if (rx_state inside {RX_START, RX_DATA, RX_STOP}) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (shift_en) shreg <= {rxs, shreg[DATA_W-1:1]};
        end
    end

    // rd_stb pops the head only when rx_rdy is high on an enabled cycle;
    // a push that finds the queue full with no pop that cycle is dropped as overrun.
`ifdef ACIA_RX_FIFO_EN
    acia_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (pclk),
        .push    (push),
        .pop     (rd_stb),
        .wr_data (shreg),
        .rd_data (rx_dat),
        .full    (full),
        .empty   (empty),
        .level   (rx_level)
    );
`else
    logic              hold_vld;
    logic [DATA_W-1:0] hold_dat;
    logic              hold_pop;
    logic              hold_push;

    assign hold_pop  = pclk && rd_stb && hold_vld;
    assign hold_push = pclk && push && (!hold_vld || hold_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_vld <= 1'b0;
            hold_dat <= '0;
        end else if (hold_push) begin
            hold_vld <= 1'b1;
            hold_dat <= shreg;
        end else if (hold_pop) begin
            hold_vld <= 1'b0;
        end
    end

    assign full     = hold_vld;
    assign empty    = !hold_vld;
    assign rx_dat   = hold_dat;
    assign rx_level = {{(LVL_W-1){1'b0}}, hold_vld};
`endif

    assign rx_rdy = !empty;

    // A set event in the same cycle as clr_err wins, so no error is ever lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_err <= 1'b0;
            rx_ovr <= 1'b0;
        end else if (pclk) begin
            if (frame_err)    rx_err <= 1'b1;
            else if (clr_err) rx_err <= 1'b0;
            if (push && full && !rd_stb) rx_ovr <= 1'b1;
            else if (clr_err)            rx_ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Bench for acia_rx_fifo: directed 8N1 frames, expected bytes queued at send time,
// a negedge monitor compares every accepted pop against the queue.
`timescale 1ns/1ps
module tb_acia_rx_fifo;

    localparam int SYM = 416;
`ifdef ACIA_RX_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       pclk      = 1'b1;
    logic       rx_serial = 1'b1;
    logic       rd_stb    = 1'b0;
    logic       clr_err   = 1'b0;
    logic [7:0] rx_dat;
    logic       rx_rdy;
    logic       rx_err;
    logic       rx_ovr;
    logic [3:0] rx_level;

    logic [7:0] exp_q[$];
    int         n_chk = 0;
    int         n_bad = 0;
    int         lat;

    always #5 clk = ~clk;

    acia_rx_fifo #(
        .clk_freq   (4000000),
        .sym_rate   (9600),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pclk      (pclk),
        .rx_serial (rx_serial),
        .rd_stb    (rd_stb),
        .clr_err   (clr_err),
        .rx_dat    (rx_dat),
        .rx_rdy    (rx_rdy),
        .rx_err    (rx_err),
        .rx_ovr    (rx_ovr),
        .rx_level  (rx_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // All driver tasks start and end aligned just after a rising edge.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_serial = 1'b0;
        repeat (SYM) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            repeat (SYM) @(posedge clk);
            #1;
        end
        rx_serial = stop;
        repeat (SYM) @(posedge clk);
        #1;
        rx_serial = 1'b1;
    endtask

    task automatic pop_one();
        rd_stb = 1'b1;
        @(posedge clk);
        #1;
        rd_stb = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n && pclk && rd_stb && rx_rdy) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_bad++;
                $display("FAIL pop_unexpected: got %0h expected nothing", rx_dat);
            end else begin
                check("pop_data", rx_dat, exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", rx_rdy, 1'b0);
        check("rst_level", rx_level, 4'd0);
        check("rst_dat", rx_dat, 8'h00);
        check("rst_err", rx_err, 1'b0);
        check("rst_ovr", rx_ovr, 1'b0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // single character and start-to-ready latency
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                lat = 0;
                while (!rx_rdy && lat < 5000) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        n_chk++;
        if (lat < 3955 || lat > 3957) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles expected 3955..3957", lat);
        end
        check("single_dat", rx_dat, 8'hA5);
        check("single_level", rx_level, 4'd1);
        pop_one();
        check("after_pop_level", rx_level, 4'd0);

        pop_one();
        check("empty_pop_level", rx_level, 4'd0);

        // short low pulse must be rejected at the start-bit check
        rx_serial = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rx_serial = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        check("glitch_level", rx_level, 4'd0);
        check("glitch_err", rx_err, 1'b0);

        // overflow: DEPTH+1 bytes, the last is dropped
        for (int i = 1; i <= DEPTH + 1; i++) begin
            if (i <= DEPTH) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
            if (i == DEPTH) check("pre_ovr", rx_ovr, 1'b0);
        end
        check("ovr_level", rx_level, 4'(DEPTH));
        check("ovr_flag", rx_ovr, 1'b1);

        pclk   = 1'b0;
        rd_stb = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rd_stb = 1'b0;
        pclk   = 1'b1;
        check("pclk_hold_level", rx_level, 4'(DEPTH));

        clr_pulse();
        check("clr_ovr", rx_ovr, 1'b0);

        // push and pop in the same cycle while full
        exp_q.push_back(8'h0A);
        fork
            send_frame(8'h0A, 1'b1);
            begin
                repeat (3954) @(posedge clk);
                #1;
                rd_stb = 1'b1;
                @(posedge clk);
                #1;
                rd_stb = 1'b0;
            end
        join
        check("simul_level", rx_level, 4'(DEPTH));
        check("simul_ovr", rx_ovr, 1'b0);
        for (int i = 0; i < DEPTH; i++) pop_one();
        check("drain_level", rx_level, 4'd0);

        // framing error, then a good byte with the flag still sticky
        send_frame(8'h3C, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("ferr_flag", rx_err, 1'b1);
        check("ferr_level", rx_level, 4'd0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        check("ferr_recover_level", rx_level, 4'd1);
        check("ferr_sticky", rx_err, 1'b1);
        clr_pulse();
        check("clr_err", rx_err, 1'b0);

        // asynchronous reset during the 4th data bit
        rx_serial = 1'b0;
        repeat (SYM) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx_serial = (i % 2 == 0);
            repeat ((i < 3) ? SYM : 200) @(posedge clk);
            #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_rdy", rx_rdy, 1'b0);
        check("mid_rst_level", rx_level, 4'd0);
        check("mid_rst_dat", rx_dat, 8'h00);
        check("mid_rst_err", rx_err, 1'b0);
        check("mid_rst_ovr", rx_ovr, 1'b0);
        exp_q.delete();
        rx_serial = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        check("post_rst_level", rx_level, 4'd1);
        check("post_rst_dat", rx_dat, 8'h5A);
        pop_one();
        check("final_level", rx_level, 4'd0);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
